// File: rtl/roce_mem_pkg.sv
// Shared types and helpers for the RoCEv2 memory command path.
package roce_mem_pkg;

    localparam int unsigned MEM_CMD_W = 96;

    // Memory command as issued by the RoCEv2 core: length in the upper word.
    typedef struct packed {
        logic [31:0] len;
        logic [63:0] addr;
    } mem_cmd_t;

    // Length of the next chunk starting at addr: limited by the bytes left,
    // the distance to the next boundary and the maximum chunk size.
    function automatic logic [31:0] chunk_len(input logic [63:0]  addr,
                                              input logic [31:0]  remaining,
                                              input int unsigned  boundary,
                                              input int unsigned  max_chunk);
        logic [31:0] bnd;
        logic [31:0] mx;
        logic [31:0] to_bnd;
        logic [31:0] lim;
        bnd    = 32'(boundary);
        mx     = 32'(max_chunk);
        // Boundary is at most 4 KiB, so only the low address bits matter.
        to_bnd = bnd - (addr[31:0] & (bnd - 32'd1));
        lim    = (to_bnd < mx) ? to_bnd : mx;
        return (remaining < lim) ? remaining : lim;
    endfunction

endpackage

// File: rtl/roce_mem_cmd_splitter.sv
// Splits memory commands into chunks that never cross a BOUNDARY-byte
// address boundary and never exceed MAX_CHUNK bytes, emitted in address order.
module roce_mem_cmd_splitter
    import roce_mem_pkg::*;
#(
    parameter int unsigned MAX_CHUNK = 4096,
    parameter int unsigned BOUNDARY  = 4096
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic [MEM_CMD_W-1:0] s_axis_cmd_tdata,
    input  logic                 s_axis_cmd_tvalid,
    output logic                 s_axis_cmd_tready,
    output logic [MEM_CMD_W-1:0] m_axis_cmd_tdata,
    output logic                 m_axis_cmd_tlast,
    output logic                 m_axis_cmd_tvalid,
    input  logic                 m_axis_cmd_tready,
    output logic [31:0]          cmd_in_count,
    output logic [31:0]          chunk_out_count,
    output logic [31:0]          zero_len_count
);

    localparam bit BoundaryOk = (BOUNDARY >= 64) && (BOUNDARY <= 4096) &&
                                ((BOUNDARY & (BOUNDARY - 1)) == 0);
    localparam bit MaxChunkOk = (MAX_CHUNK >= 64) && (MAX_CHUNK <= BOUNDARY) &&
                                ((MAX_CHUNK & (MAX_CHUNK - 1)) == 0);

    if (!(BoundaryOk && MaxChunkOk)) begin : g_param_check
        $error("roce_mem_cmd_splitter: illegal BOUNDARY/MAX_CHUNK");
    end

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StSplit = 1'b1;

    logic [0:0]  state_q, state_d;
    logic        started_q;
    logic [63:0] cur_addr_q, cur_addr_d;
    logic [31:0] remaining_q, remaining_d;
    mem_cmd_t    out_data_q, out_data_d;
    logic        out_last_q, out_last_d;
    logic        out_valid_q, out_valid_d;

    mem_cmd_t    in_cmd;
    logic        in_hs;
    logic        out_hs;
    logic [63:0] src_addr;
    logic [31:0] src_rem;
    logic [31:0] clen;
    logic        load;

    assign in_cmd = s_axis_cmd_tdata;

    // started_q keeps tready low until the first edge after reset release.
    assign s_axis_cmd_tready = started_q && (state_q == StIdle);
    assign in_hs  = s_axis_cmd_tvalid && s_axis_cmd_tready;
    assign out_hs = out_valid_q && m_axis_cmd_tready;

    // One chunk_len instance: fed by the new command in IDLE, by the residue in SPLIT.
    assign src_addr = (state_q == StIdle) ? in_cmd.addr : cur_addr_q;
    assign src_rem  = (state_q == StIdle) ? in_cmd.len  : remaining_q;
    assign clen     = chunk_len(src_addr, src_rem, BOUNDARY, MAX_CHUNK);

    assign m_axis_cmd_tdata  = out_data_q;
    assign m_axis_cmd_tlast  = out_last_q;
    assign m_axis_cmd_tvalid = out_valid_q;

    // Next-state: load a chunk on accept or on a non-final output handshake.
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        load        = 1'b0;

        if (state_q == StIdle) begin
            if (in_hs && (in_cmd.len != 32'd0)) begin
                load    = 1'b1;
                state_d = StSplit;
            end
        end else begin
            if (out_hs) begin
                if (out_last_q) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = StIdle;
                end else begin
                    load = 1'b1;
                end
            end
        end

        if (load) begin
            out_data_d.addr = src_addr;
            out_data_d.len  = clen;
            out_last_d      = (src_rem == clen);
            out_valid_d     = 1'b1;
            // Address space wraps silently at 2^64.
            cur_addr_d      = src_addr + {32'd0, clen};
            remaining_d     = src_rem - clen;
        end
    end

    // FSM, working registers and output register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= StIdle;
            started_q   <= 1'b0;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            started_q   <= 1'b1;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Wrapping event counters.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cmd_in_count    <= '0;
            chunk_out_count <= '0;
            zero_len_count  <= '0;
        end else begin
            if (in_hs) begin
                cmd_in_count <= cmd_in_count + 32'd1;
            end
            if (in_hs && (in_cmd.len == 32'd0)) begin
                zero_len_count <= zero_len_count + 32'd1;
            end
            if (out_hs) begin
                chunk_out_count <= chunk_out_count + 32'd1;
            end
        end
    end

endmodule
